// File: rtl/esp_dma64_sram_slave.sv
// esp_dma64_sram_slave: 64-bit ESP DMA responder backed by a local SRAM.
// Serves read bursts and absorbs write bursts for external-slave bring-up.
module esp_dma64_sram_slave #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_read_ctrl_valid,
  output logic                  dma_read_ctrl_ready,
  input  logic [31:0]           dma_read_ctrl_data_index,
  input  logic [31:0]           dma_read_ctrl_data_length,
  input  logic [2:0]            dma_read_ctrl_data_size,
  output logic                  dma_read_chnl_valid,
  input  logic                  dma_read_chnl_ready,
  output logic [DATA_WIDTH-1:0] dma_read_chnl_data,
  input  logic                  dma_write_ctrl_valid,
  output logic                  dma_write_ctrl_ready,
  input  logic [31:0]           dma_write_ctrl_data_index,
  input  logic [31:0]           dma_write_ctrl_data_length,
  input  logic [2:0]            dma_write_ctrl_data_size,
  input  logic                  dma_write_chnl_valid,
  output logic                  dma_write_chnl_ready,
  input  logic [DATA_WIDTH-1:0] dma_write_chnl_data,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RD_FETCH,
    RD_DATA,
    WR_DATA
  } state_t;

  state_t                state;
  logic [AW-1:0]         ptr;
  logic [31:0]           rem;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic        idle;
  logic        rd_acc;
  logic        wr_acc;
  logic        rd_beat;
  logic        wr_beat;
  logic        last;
  logic [31:0] cmd_idx;
  logic [31:0] cmd_len;
  logic [2:0]  cmd_size;
  logic        unused_idx;

  assign idle = (state == IDLE);

  assign dma_read_ctrl_ready  = idle && !rst;
  assign dma_write_ctrl_ready = idle && !rst
                                && !dma_read_ctrl_valid;

  assign rd_acc = dma_read_ctrl_valid
                  && dma_read_ctrl_ready;
  assign wr_acc = dma_write_ctrl_valid
                  && dma_write_ctrl_ready;

  assign rd_beat = (state == RD_DATA)
                   && dma_read_chnl_ready;
  assign wr_beat = (state == WR_DATA)
                   && dma_write_chnl_valid;
  assign last    = (rem == 32'd1);

  assign dma_read_chnl_valid  = (state == RD_DATA);
  assign dma_read_chnl_data   = rdata;
  assign dma_write_chnl_ready = (state == WR_DATA);
  assign busy_o               = !idle;
  assign err_o                = err;

  // Select the accepted command; read wins when both are valid.
  always_comb begin
    cmd_idx  = dma_write_ctrl_data_index;
    cmd_len  = dma_write_ctrl_data_length;
    cmd_size = dma_write_ctrl_data_size;
    if (dma_read_ctrl_valid) begin
      cmd_idx  = dma_read_ctrl_data_index;
      cmd_len  = dma_read_ctrl_data_length;
      cmd_size = dma_read_ctrl_data_size;
    end
  end

  // Index bits above the SRAM address range alias onto it.
  assign unused_idx = ^cmd_idx[31:AW];

  // Burst sequencer: pointer, remaining count, read data and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc || wr_acc) begin
            ptr <= cmd_idx[AW-1:0];
            rem <= cmd_len;
            if (cmd_size != 3'b011)
              err <= 1'b1;
            if (cmd_len != 32'd0)
              state <= rd_acc ? RD_FETCH : WR_DATA;
          end
        end
        RD_FETCH: begin
          rdata <= mem[ptr];
          state <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_beat) begin
            rem   <= rem - 32'd1;
            ptr   <= ptr + 1'b1;
            state <= last ? IDLE : RD_FETCH;
          end
        end
        WR_DATA: begin
          if (wr_beat) begin
            rem   <= rem - 32'd1;
            ptr   <= ptr + 1'b1;
            state <= last ? IDLE : WR_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM write port; array is never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_beat)
      mem[ptr] <= dma_write_chnl_data;
  end

endmodule

// File: doc/esp_dma64_sram_slave.md
# esp_dma64_sram_slave

On-chip responder for the 64-bit ESP DMA master interface driven by the OBI-to-ESP-DMA bridge. It accepts read and write control commands and serves or consumes burst data beats against an internal word-addressed SRAM. It is the downstream stage used for standalone bring-up and simulation of the external-slave window without the ESP NoC.

## Interface
- DATA_WIDTH, 64, data beat width; only 64 is supported.
- DEPTH_WORDS, 1024, SRAM depth in DATA_WIDTH words; must be a power of two. AW = $clog2(DEPTH_WORDS).

Ports:
- clk  in  1  clock; all logic is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- dma_read_ctrl_valid  in  1  read command valid.
- dma_read_ctrl_ready  out  1  read command accept.
- dma_read_ctrl_data_index  in  32  first word index.
- dma_read_ctrl_data_length  in  32  number of beats.
- dma_read_ctrl_data_size  in  3  beat size code; only 3'b011 (64-bit) is legal.
- dma_read_chnl_valid  out  1  read beat valid.
- dma_read_chnl_ready  in  1  read beat accept.
- dma_read_chnl_data  out  DATA_WIDTH  read beat.
- dma_write_ctrl_valid / _ready / _data_index / _data_length / _data_size: same widths and roles as the read control group.
- dma_write_chnl_valid  in  1  write beat valid.
- dma_write_chnl_ready  out  1  write beat accept.
- dma_write_chnl_data  in  DATA_WIDTH  write beat.
- busy_o  out  1  high whenever the state is not IDLE.
- err_o  out  1  sticky flag for an illegal size code; cleared only by rst.

## Operation
- States: IDLE, RD_FETCH, RD_DATA, WR_DATA.
- IDLE:
  - Both ctrl_ready outputs are 1.
  - If read ctrl is valid, it is accepted. Read has fixed priority, so write_ctrl_ready is 0 in any cycle where read ctrl is valid.
  - Otherwise, a valid write ctrl is accepted.
- On accept:
  - ptr is loaded with index[AW-1:0]; upper index bits are ignored.
  - rem is loaded with length (32-bit).
  - If size != 3'b011, err_o is set. The burst still executes as 64-bit beats.
- Length 0: the command is accepted and the block stays in IDLE. No beats are produced or consumed.
- Read, length > 0: the next state is RD_FETCH.
  - RD_FETCH issues an SRAM read at ptr. The data register loads mem[ptr] at the end of this cycle. Next state is RD_DATA.
  - RD_DATA drives read_chnl_valid = 1. data is held stable until the beat is accepted.
  - On read_chnl_ready: rem decrements and ptr increments modulo DEPTH_WORDS. If rem was 1, the next state is IDLE; otherwise RD_FETCH.
- Write, length > 0: the next state is WR_DATA.
  - write_chnl_ready is 1 in WR_DATA.
  - On each write_chnl_valid: mem[ptr] is written, ptr increments modulo DEPTH_WORDS and rem decrements. After the last beat the next state is IDLE.
- The SRAM array is not reset, and its contents survive rst.

## Timing
- Reset values: state is IDLE and all counters are 0.
  - dma_read_chnl_valid = 0, dma_read_chnl_data = 0, dma_write_chnl_ready = 0, busy_o = 0, err_o = 0.
  - Both ctrl_ready outputs are 1 from the first cycle after reset is released.
- Read latency: with the ctrl handshake in cycle T, read_chnl_valid is first high in T+2. Each subsequent beat arrives no earlier than 2 cycles after the previous handshake (one RD_FETCH cycle plus one RD_DATA cycle).
- Write throughput: with the ctrl handshake in cycle T, write_chnl_ready is high from T+1 on. One beat per cycle is accepted. A written word is readable by a command accepted in the cycle after the final write beat.
- Backpressure: in RD_DATA with valid=1 and ready=0, valid and data hold unchanged indefinitely.
- The ctrl_ready outputs are 0 in every non-IDLE state. Commands presented during a burst wait for IDLE.
- Wrap-around: ptr = DEPTH_WORDS-1 followed by an increment gives 0.
- Reset mid-burst: the next cycle is IDLE with all outputs at reset values. The remaining beats are dropped and SRAM writes already committed persist.
- write_chnl_valid outside WR_DATA is ignored. read_chnl_ready outside RD_DATA is ignored.

## Test plan
- Single write then read:
  - Write ctrl index=5, len=1, size=3; data 0x1122334455667788.
  - Then read ctrl index=5, len=1.
  - Required: read_chnl_valid is high 2 cycles after the ctrl handshake, data is 0x1122334455667788, err_o stays 0.
- Wrap-around burst (DEPTH_WORDS=1024):
  - Write index=1022, len=4, data 0xA0..0xA3.
  - Read index=1022, len=4.
  - Required: beats A0, A1, A2, A3, with mem[0]=A2 and mem[1]=A3. Also read index=0x400 (aliases to 0), len=1, and require data A2.
- Read backpressure: hold read_chnl_ready=0 for 5 cycles during RD_DATA; require valid=1 and identical data in every cycle, and exactly one beat consumed on release.
- Simultaneous commands:
  - Stimulus: read ctrl and write ctrl valid in the same IDLE cycle.
  - Required: only the read is accepted (write_ctrl_ready=0 in that cycle), and the write is accepted in the first IDLE cycle after the read burst ends.
- Length 0 and illegal size:
  - Write ctrl len=0 is accepted, busy_o stays 0, and SRAM is unchanged.
  - Read ctrl with size=3'b010 sets err_o=1, and err_o stays 1 until rst.
- Reset mid-burst: assert rst after 2 of 4 write beats. Require IDLE on the next cycle with write_chnl_ready=0, the first 2 words retained and the other 2 unchanged.
